relu_window_sequencer: RTL and testbench

- Sequences the MAC-accumulator → truncate/ReLU stage of one CNN convolution channel.
- Generates the per-window tap counter `count_sload` that the accumulator and ReLU stage share.
- Generates the accumulator reload strobe, output-valid and output index for each finished pixel.
- Walks a programmed number of output windows per frame, then drains the last window through the ReLU capture point and signals done.

---
 rtl/cnn_ctrl_pkg.sv | 16 +
 rtl/window_tap_counter.sv | 26 ++
 rtl/relu_window_sequencer.sv | 103 ++++++++++
 tb/tb_relu_window_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cnn_ctrl_pkg.sv
// Shared control types and default geometry for the CNN conv-channel
// accumulator / ReLU sequencing blocks.
package cnn_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } ctrl_state_t;

  localparam int MAC_CYCLES_DEF    = 25;
  localparam int CAPTURE_COUNT_DEF = 2;
  localparam int NUM_OUTPUTS_DEF   = 576;

endpackage

// File: rtl/window_tap_counter.sv
// Per-window tap counter: modulo-MODULUS up counter with enable, load
// and a flag marking the last tap. Resets to the parked (last) value.
module window_tap_counter #(
  parameter int WIDTH   = 5,
  parameter int MODULUS = 25
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  assign wrap = (count == LAST);

  always_ff @(posedge clock) begin
    if (reset)     count <= LAST;
    else if (load) count <= load_val;
    else if (en)   count <= wrap ? '0 : count + WIDTH'(1);
  end

endmodule

// File: rtl/relu_window_sequencer.sv
// Sequences the MAC-accumulator -> truncate/ReLU stage of one conv channel:
// tap counter, accumulator reload, per-pixel valid/index and frame done.
module relu_window_sequencer
  import cnn_ctrl_pkg::*;
#(
  parameter int COUNT_SLOAD_BITWIDTH = 5,
  parameter int MAC_CYCLES           = MAC_CYCLES_DEF,
  parameter int CAPTURE_COUNT        = CAPTURE_COUNT_DEF,
  parameter int NUM_OUTPUTS          = NUM_OUTPUTS_DEF,
  parameter int OUT_INDEX_BITWIDTH   = 10
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            enable,
  output logic [COUNT_SLOAD_BITWIDTH-1:0] count_sload,
  output logic                            sload,
  output logic                            out_valid,
  output logic [OUT_INDEX_BITWIDTH-1:0]   out_index,
  output logic                            busy,
  output logic                            done
);

  localparam int CW = COUNT_SLOAD_BITWIDTH;
  localparam int IW = OUT_INDEX_BITWIDTH;
  localparam logic [CW-1:0] CAP      = CW'(CAPTURE_COUNT);
  localparam logic [CW-1:0] PARK     = CW'(MAC_CYCLES - 1);
  localparam logic [IW-1:0] LAST_WIN = IW'(NUM_OUTPUTS - 1);

  ctrl_state_t   state;
  logic [IW-1:0] win;
  logic          cnt_wrap;
  logic          cnt_load;
  logic [CW-1:0] cnt_load_val;
  logic          capture;

  assign busy    = (state == ST_RUN) || (state == ST_DRAIN);
  assign sload   = (state == ST_RUN) && (count_sload == '0) && enable;
  assign capture = enable && (count_sload == CAP);

  // Outside RUN/DRAIN the counter is held at PARK so the ReLU stage never
  // sees CAP; a start loads 0, and the drain capture re-parks it.
  assign cnt_load     = !busy || ((state == ST_DRAIN) && capture);
  assign cnt_load_val = ((state == ST_IDLE) && start) ? '0 : PARK;

  window_tap_counter #(
    .WIDTH   (CW),
    .MODULUS (MAC_CYCLES)
  ) u_tap_cnt (
    .clock    (clock),
    .reset    (reset),
    .en       (busy && enable),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .count    (count_sload),
    .wrap     (cnt_wrap)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      win       <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      done      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            win   <= '0;
          end
        end
        ST_RUN: begin
          if (enable) begin
            // Capture during window N publishes the accumulation of window N-1.
            if (capture && (win != '0)) begin
              out_valid <= 1'b1;
              out_index <= win - IW'(1);
            end
            if (cnt_wrap) begin
              if (win == LAST_WIN) state <= ST_DRAIN;
              else                 win   <= win + IW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (capture) begin
            out_valid <= 1'b1;
            out_index <= LAST_WIN;
            state     <= ST_DONE;
            done      <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_relu_window_sequencer.sv
// Directed bench: small geometry (4/2/3) driven from per-cycle vector tables,
// plus one full default-geometry frame checked for count, order and latency.
module tb_relu_window_sequencer;

  localparam int CW = 5;
  localparam int IW = 10;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, start, enable;
  logic [CW-1:0] count_sload;
  logic          sload, out_valid, busy, done;
  logic [IW-1:0] out_index;

  logic          reset_d, start_d, enable_d;
  logic [CW-1:0] count_sload_d;
  logic          sload_d, out_valid_d, busy_d, done_d;
  logic [IW-1:0] out_index_d;

  relu_window_sequencer #(
    .COUNT_SLOAD_BITWIDTH (CW),
    .MAC_CYCLES           (4),
    .CAPTURE_COUNT        (2),
    .NUM_OUTPUTS          (3),
    .OUT_INDEX_BITWIDTH   (IW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .enable      (enable),
    .count_sload (count_sload),
    .sload       (sload),
    .out_valid   (out_valid),
    .out_index   (out_index),
    .busy        (busy),
    .done        (done)
  );

  relu_window_sequencer #(
    .COUNT_SLOAD_BITWIDTH (CW),
    .MAC_CYCLES           (25),
    .CAPTURE_COUNT        (2),
    .NUM_OUTPUTS          (576),
    .OUT_INDEX_BITWIDTH   (IW)
  ) dut_def (
    .clock       (clock),
    .reset       (reset_d),
    .start       (start_d),
    .enable      (enable_d),
    .count_sload (count_sload_d),
    .sload       (sload_d),
    .out_valid   (out_valid_d),
    .out_index   (out_index_d),
    .busy        (busy_d),
    .done        (done_d)
  );

  typedef struct {
    logic start;
    logic enable;
    int   cnt;
    logic sl;
    logic ov;
    int   idx;
    logic bsy;
    logic dn;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  vec_t base[18];
  vec_t seq[$];

  function automatic vec_t mk(logic s, logic e, int c, logic sl, logic ov,
                              int idx, logic b, logic d);
    vec_t v;
    v.start = s; v.enable = e; v.cnt = c; v.sl = sl; v.ov = ov;
    v.idx = idx; v.bsy = b; v.dn = d;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Entered at posedge+1; each entry drives one cycle and checks it at posedge+3.
  task automatic run_seq(input string tag);
    for (int i = 0; i < seq.size(); i++) begin
      start  = seq[i].start;
      enable = seq[i].enable;
      #2;
      chk($sformatf("%s[%0d].count_sload", tag, i), int'(count_sload), seq[i].cnt);
      chk($sformatf("%s[%0d].sload", tag, i), int'(sload), int'(seq[i].sl));
      chk($sformatf("%s[%0d].out_valid", tag, i), int'(out_valid), int'(seq[i].ov));
      chk($sformatf("%s[%0d].busy", tag, i), int'(busy), int'(seq[i].bsy));
      chk($sformatf("%s[%0d].done", tag, i), int'(done), int'(seq[i].dn));
      if (seq[i].ov)
        chk($sformatf("%s[%0d].out_index", tag, i), int'(out_index), seq[i].idx);
      @(posedge clock); #1;
    end
    start = 1'b0;
  endtask

  initial begin
    int   cyc, pulses, last_idx, done_cyc;
    logic order_ok, got_done;

    // Basic frame, MAC=4 CAP=2 N=3: cycle k after start is entry k.
    base[0]  = mk(1, 1, 3, 0, 0, 0, 0, 0);
    base[1]  = mk(0, 1, 0, 1, 0, 0, 1, 0);
    base[2]  = mk(0, 1, 1, 0, 0, 0, 1, 0);
    base[3]  = mk(0, 1, 2, 0, 0, 0, 1, 0);
    base[4]  = mk(0, 1, 3, 0, 0, 0, 1, 0);
    base[5]  = mk(0, 1, 0, 1, 0, 0, 1, 0);
    base[6]  = mk(0, 1, 1, 0, 0, 0, 1, 0);
    base[7]  = mk(0, 1, 2, 0, 0, 0, 1, 0);
    base[8]  = mk(0, 1, 3, 0, 1, 0, 1, 0);
    base[9]  = mk(0, 1, 0, 1, 0, 0, 1, 0);
    base[10] = mk(0, 1, 1, 0, 0, 0, 1, 0);
    base[11] = mk(0, 1, 2, 0, 0, 0, 1, 0);
    base[12] = mk(0, 1, 3, 0, 1, 1, 1, 0);
    base[13] = mk(0, 1, 0, 0, 0, 0, 1, 0);
    base[14] = mk(0, 1, 1, 0, 0, 0, 1, 0);
    base[15] = mk(0, 1, 2, 0, 0, 0, 1, 0);
    base[16] = mk(0, 1, 3, 0, 1, 2, 0, 1);
    base[17] = mk(0, 1, 3, 0, 0, 0, 0, 0);

    reset = 1'b1; start = 1'b0; enable = 1'b1;
    reset_d = 1'b1; start_d = 1'b0; enable_d = 1'b1;
    repeat (3) @(posedge clock);
    #3;
    chk("reset.count_sload", int'(count_sload), 3);
    chk("reset.out_valid", int'(out_valid), 0);
    chk("reset.out_index", int'(out_index), 0);
    chk("reset.done", int'(done), 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.sload", int'(sload), 0);
    @(posedge clock); #1;
    reset = 1'b0; reset_d = 1'b0;
    @(posedge clock); #1;

    seq.delete();
    foreach (base[i]) seq.push_back(base[i]);
    run_seq("basic");

    // Stall 3 cycles at count 2 of window 1; everything after shifts by 3.
    seq.delete();
    for (int i = 0; i <= 6; i++) seq.push_back(base[i]);
    repeat (3) seq.push_back(mk(0, 0, 2, 0, 0, 0, 1, 0));
    for (int i = 7; i <= 17; i++) seq.push_back(base[i]);
    run_seq("stall");

    // Reset while in window 1 with count 1.
    seq.delete();
    for (int i = 0; i <= 5; i++) seq.push_back(base[i]);
    run_seq("rst_pre");
    reset = 1'b1; enable = 1'b1;
    #2;
    chk("rst_mid.count_before", int'(count_sload), 1);
    @(posedge clock); #1;
    reset = 1'b0;
    seq.delete();
    repeat (4) seq.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0));
    run_seq("rst_after");
    seq.delete();
    foreach (base[i]) seq.push_back(base[i]);
    run_seq("rst_frame");

    // Start pulses in RUN, DRAIN and DONE must be ignored.
    seq.delete();
    foreach (base[i]) seq.push_back(base[i]);
    seq[3].start = 1'b1;
    seq[13].start = 1'b1;
    seq[16].start = 1'b1;
    seq.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0));
    run_seq("start_busy");

    // Second frame started on the first IDLE cycle after done.
    seq.delete();
    for (int i = 0; i <= 16; i++) seq.push_back(base[i]);
    foreach (base[i]) seq.push_back(base[i]);
    run_seq("b2b");

    // Full default-geometry frame.
    start_d = 1'b1;
    @(posedge clock); #1;
    start_d = 1'b0;
    cyc = 1; pulses = 0; last_idx = -1; done_cyc = -1;
    order_ok = 1'b1; got_done = 1'b0;
    while (!got_done && cyc <= 20000) begin
      #2;
      if (out_valid_d) begin
        if (int'(out_index_d) != pulses) order_ok = 1'b0;
        pulses++;
        last_idx = int'(out_index_d);
      end
      if (done_d) begin
        got_done = 1'b1;
        done_cyc = cyc;
      end
      @(posedge clock); #1;
      cyc++;
    end
    chk("default.done_seen", int'(got_done), 1);
    chk("default.done_cycle", done_cyc, 14404);
    chk("default.pulses", pulses, 576);
    chk("default.last_index", last_idx, 575);
    chk("default.index_order", int'(order_ok), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
